// File: rtl/song_pkg.sv
// Shared song-path definitions: default geometry, recorder state encoding,
// and the layout of one note word {keys[7:0], octave[3:0]}.
// Imported by the recorder, its bus interface and the playback side.
package song_pkg;

  localparam int ENCODING_LEN = 12;
  localparam int ADDR_W       = 6;
  localparam int SONG_MAX     = 64;

  // Field offsets inside a note word.
  localparam int KEYS_LSB = 4;
  localparam int OCT_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    RECORD = 2'd2,
    DONE   = 2'd3
  } state_e;

  function automatic logic [ENCODING_LEN-1:0] pack_note(input logic [7:0] keys,
                                                        input logic [3:0] octave);
    logic [ENCODING_LEN-1:0] note;
    note                 = '0;
    note[KEYS_LSB +: 8]  = keys;
    note[OCT_LSB  +: 4]  = octave;
    return note;
  endfunction

endpackage

// File: rtl/song_recorder_if.sv
// Bus between the keyboard/tempo front end (master) and the song recorder (slave).
// master drives start/stop/tick/keys/octave; slave drives the song memory write
// port (wr_en/wr_addr/wr_data) and status (recording, done, rec_len).
interface song_recorder_if #(
  parameter int ENCODING_LEN = song_pkg::ENCODING_LEN,
  parameter int ADDR_W       = song_pkg::ADDR_W
);
  logic                    start;
  logic                    stop;
  logic                    tick;
  logic [7:0]              keys;
  logic [3:0]              octave;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [ENCODING_LEN-1:0] wr_data;
  logic                    recording;
  logic                    done;
  logic [ADDR_W:0]         rec_len;

  modport master (
    output start, stop, tick, keys, octave,
    input  wr_en, wr_addr, wr_data, recording, done, rec_len
  );

  modport slave (
    input  start, stop, tick, keys, octave,
    output wr_en, wr_addr, wr_data, recording, done, rec_len
  );
endinterface

// File: rtl/song_recorder_key_sync.sv
// key_sync: two-flop synchronizer for a bundle of slow GPIO bits.
// Latency: 2 cycles, q reflects d as seen two clocks earlier. No backpressure.
// Ports: clk, rst_n (async, active-low, clears both stages), d in, q out.
module key_sync #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/song_recorder.sv
// song_recorder: captures {keys, octave} once per metronome tick into song memory.
// Latency: the write for a tick in cycle N appears at N+1 (one-cycle wr_en strobe).
// Backpressure: none; memory accepts one write per cycle, ticks are never stalled.
// Ports: clk, rst_n (async active-low); bus (song_recorder_if.slave) carrying
//   start/stop/tick/keys/octave in and wr_en/wr_addr/wr_data/recording/done/rec_len out.
// Option: define SONG_RECORDER_SYNC_EN to pass keys/octave through key_sync first
//   (sample at tick N then reflects the pins at N-2; write timing is unchanged).
// SONG_MAX must satisfy 1 <= SONG_MAX <= 2**ADDR_W.
module song_recorder #(
  parameter int ENCODING_LEN = song_pkg::ENCODING_LEN,
  parameter int ADDR_W       = song_pkg::ADDR_W,
  parameter int SONG_MAX     = song_pkg::SONG_MAX
) (
  input logic            clk,
  input logic            rst_n,
  song_recorder_if.slave bus
);
  import song_pkg::*;

  localparam int CNT_W = ADDR_W + 1;

  logic [ENCODING_LEN-1:0] pin_note;
  logic [ENCODING_LEN-1:0] smp_note;
  state_e                  state;
  logic [CNT_W-1:0]        cnt;       // write pointer, doubles as take length
  logic                    wr_en_q;
  logic [ADDR_W-1:0]       wr_addr_q;
  logic [ENCODING_LEN-1:0] wr_data_q;
  logic                    recording_q;
  logic                    done_q;
  logic                    last_note;

  assign pin_note = pack_note(bus.keys, bus.octave);

`ifdef SONG_RECORDER_SYNC_EN
  key_sync #(.W(ENCODING_LEN)) u_key_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pin_note),
    .q     (smp_note)
  );
`else
  assign smp_note = pin_note;
`endif

  // The tick that writes this note fills the song; no wrap-around.
  assign last_note = (cnt == CNT_W'(SONG_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      recording_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // start beats a coincident stop; tick and stop are ignored here.
          if (bus.start) begin
            state       <= ARMED;
            cnt         <= '0;
            recording_q <= 1'b1;
            done_q      <= 1'b0;
          end
        end
        ARMED, RECORD: begin
          // start is ignored while a take is open.
          if (bus.tick) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= cnt[ADDR_W-1:0];
            wr_data_q <= smp_note;
            cnt       <= cnt + 1'b1;
            state     <= RECORD;
          end
          // A stop alongside a tick still keeps that tick's note.
          if (bus.stop || (bus.tick && last_note)) begin
            state       <= DONE;
            recording_q <= 1'b0;
            done_q      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.recording = recording_q;
  assign bus.done      = done_q;
  assign bus.rec_len   = cnt;

endmodule

// File: tb/tb_song_recorder.sv
// Bench for song_recorder: a full-size instance (SONG_MAX=64) driven from a
// vector table plus hand sequences, and a SONG_MAX=4 instance for the full case.
module tb_song_recorder;
  import song_pkg::*;

`ifdef SONG_RECORDER_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [5:0]  addr;
    logic [11:0] data;
    logic        rec;
    logic        done;
    logic [6:0]  len;
  } out_t;

  typedef struct {
    logic       start;
    logic       stop;
    logic       tick;
    logic [7:0] keys;
    logic [3:0] oct;
    out_t       exp;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   nvec  = 0;
  int   nbad  = 0;

  always #5 clk = ~clk;

  song_recorder_if #(.ENCODING_LEN(12), .ADDR_W(6)) bus  ();
  song_recorder_if #(.ENCODING_LEN(12), .ADDR_W(6)) bus4 ();

  song_recorder #(.ENCODING_LEN(12), .ADDR_W(6), .SONG_MAX(64)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  song_recorder #(.ENCODING_LEN(12), .ADDR_W(6), .SONG_MAX(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  function automatic out_t o(input logic we, input logic [5:0] a, input logic [11:0] d,
                             input logic rec, input logic dn, input logic [6:0] len);
    out_t r;
    r.we = we; r.addr = a; r.data = d; r.rec = rec; r.done = dn; r.len = len;
    return r;
  endfunction

  function automatic vec_t v(input logic s, input logic p, input logic t,
                             input logic [7:0] k, input logic [3:0] oc, input out_t e);
    vec_t r;
    r.start = s; r.stop = p; r.tick = t; r.keys = k; r.oct = oc; r.exp = e;
    return r;
  endfunction

  function automatic out_t get(input bit sel4);
    out_t r;
    if (sel4) r = o(bus4.wr_en, bus4.wr_addr, bus4.wr_data, bus4.recording, bus4.done, bus4.rec_len);
    else      r = o(bus.wr_en,  bus.wr_addr,  bus.wr_data,  bus.recording,  bus.done,  bus.rec_len);
    return r;
  endfunction

  // Address/data are only meaningful with a write strobe, unless 'full' is set.
  task automatic chk(input string nm, input bit full, input out_t a, input out_t e);
    bit ok;
    nvec++;
    ok = (a.we === e.we) && (a.rec === e.rec) && (a.done === e.done) && (a.len === e.len);
    if (full || e.we) ok = ok && (a.addr === e.addr) && (a.data === e.data);
    if (!ok) begin
      nbad++;
      $display("FAIL %s: got we=%b addr=%0d data=%h rec=%b done=%b len=%0d, want we=%b addr=%0d data=%h rec=%b done=%b len=%0d",
               nm, a.we, a.addr, a.data, a.rec, a.done, a.len,
               e.we, e.addr, e.data, e.rec, e.done, e.len);
    end
  endtask

  task automatic drive(input bit sel4, input logic s, input logic p, input logic t,
                       input logic [7:0] k, input logic [3:0] oc);
    @(negedge clk);
    bus.start  = 1'b0; bus.stop  = 1'b0; bus.tick  = 1'b0; bus.keys  = '0; bus.octave  = '0;
    bus4.start = 1'b0; bus4.stop = 1'b0; bus4.tick = 1'b0; bus4.keys = '0; bus4.octave = '0;
    if (sel4) begin
      bus4.start = s; bus4.stop = p; bus4.tick = t; bus4.keys = k; bus4.octave = oc;
    end else begin
      bus.start = s; bus.stop = p; bus.tick = t; bus.keys = k; bus.octave = oc;
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vt[$];

  initial begin
    bus.start  = 1'b0; bus.stop  = 1'b0; bus.tick  = 1'b0; bus.keys  = '0; bus.octave  = '0;
    bus4.start = 1'b0; bus4.stop = 1'b0; bus4.tick = 1'b0; bus4.keys = '0; bus4.octave = '0;

    // Every tick row keeps keys stable for the two rows before it, so the
    // expectations hold with or without the input synchronizer.
    vt.push_back(v(0,0,0,8'h00,4'h0, o(0,0,12'h000,0,0,0)));   // 0 idle
    vt.push_back(v(1,0,0,8'hA5,4'h3, o(0,0,12'h000,1,0,0)));   // 1 start -> ARMED
    vt.push_back(v(0,0,0,8'hA5,4'h3, o(0,0,12'h000,1,0,0)));   // 2
    vt.push_back(v(0,0,1,8'hA5,4'h3, o(1,0,12'hA53,1,0,1)));   // 3 note 0
    vt.push_back(v(0,0,0,8'h01,4'h0, o(0,0,12'h000,1,0,1)));   // 4 single-cycle strobe
    vt.push_back(v(0,0,0,8'h01,4'h0, o(0,0,12'h000,1,0,1)));   // 5
    vt.push_back(v(0,0,1,8'h01,4'h0, o(1,1,12'h010,1,0,2)));   // 6 note 1
    vt.push_back(v(0,1,0,8'h00,4'h0, o(0,0,12'h000,0,1,2)));   // 7 stop
    vt.push_back(v(0,0,0,8'h00,4'h0, o(0,0,12'h000,0,1,2)));   // 8 rec_len holds
    vt.push_back(v(0,0,1,8'h11,4'h1, o(0,0,12'h000,0,1,2)));   // 9 tick in DONE ignored
    vt.push_back(v(1,1,0,8'h11,4'h1, o(0,0,12'h000,1,0,0)));   // 10 start+stop in DONE
    vt.push_back(v(0,0,0,8'h11,4'h1, o(0,0,12'h000,1,0,0)));   // 11
    vt.push_back(v(0,0,1,8'h11,4'h1, o(1,0,12'h111,1,0,1)));   // 12
    vt.push_back(v(0,0,0,8'h22,4'h2, o(0,0,12'h000,1,0,1)));   // 13
    vt.push_back(v(0,0,0,8'h22,4'h2, o(0,0,12'h000,1,0,1)));   // 14
    vt.push_back(v(0,0,1,8'h22,4'h2, o(1,1,12'h222,1,0,2)));   // 15
    vt.push_back(v(0,0,0,8'h33,4'h3, o(0,0,12'h000,1,0,2)));   // 16
    vt.push_back(v(0,0,0,8'h33,4'h3, o(0,0,12'h000,1,0,2)));   // 17
    vt.push_back(v(0,1,1,8'h33,4'h3, o(1,2,12'h333,0,1,3)));   // 18 stop with 3rd tick
    vt.push_back(v(0,0,0,8'h00,4'h0, o(0,0,12'h000,0,1,3)));   // 19
    vt.push_back(v(1,0,0,8'h00,4'h0, o(0,0,12'h000,1,0,0)));   // 20 start
    vt.push_back(v(0,1,0,8'h00,4'h0, o(0,0,12'h000,0,1,0)));   // 21 stop in ARMED
    vt.push_back(v(0,0,1,8'h00,4'h0, o(0,0,12'h000,0,1,0)));   // 22 tick in DONE
    vt.push_back(v(0,0,0,8'h00,4'h0, o(0,0,12'h000,0,1,0)));   // 23
    vt.push_back(v(1,0,0,8'hFF,4'hF, o(0,0,12'h000,1,0,0)));   // 24 start
    vt.push_back(v(0,0,0,8'hFF,4'hF, o(0,0,12'h000,1,0,0)));   // 25
    vt.push_back(v(0,0,1,8'hFF,4'hF, o(1,0,12'hFFF,1,0,1)));   // 26
    vt.push_back(v(1,0,0,8'h0F,4'h5, o(0,0,12'h000,1,0,1)));   // 27 start in RECORD ignored
    vt.push_back(v(0,0,0,8'h0F,4'h5, o(0,0,12'h000,1,0,1)));   // 28
    vt.push_back(v(0,0,1,8'h0F,4'h5, o(1,1,12'h0F5,1,0,2)));   // 29
    vt.push_back(v(1,1,0,8'h0F,4'h5, o(0,0,12'h000,0,1,2)));   // 30 start+stop in RECORD
    vt.push_back(v(1,0,0,8'h0F,4'h5, o(0,0,12'h000,1,0,0)));   // 31 start
    vt.push_back(v(0,1,1,8'h0F,4'h5, o(1,0,12'h0F5,0,1,1)));   // 32 tick+stop in ARMED

    // Reset state of both instances.
    #12;
    chk("reset", 1'b1, get(1'b0), o(0,0,12'h000,0,0,0));
    chk("reset4", 1'b1, get(1'b1), o(0,0,12'h000,0,0,0));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      drive(1'b0, vt[i].start, vt[i].stop, vt[i].tick, vt[i].keys, vt[i].oct);
      chk($sformatf("vec%0d", i), 1'b0, get(1'b0), vt[i].exp);
    end

    // Full take on the SONG_MAX=4 instance: six ticks, exactly four writes.
    drive(1'b1, 1, 0, 0, 8'hC3, 4'h9);
    drive(1'b1, 0, 0, 0, 8'hC3, 4'h9);
    drive(1'b1, 0, 0, 0, 8'hC3, 4'h9);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 0, 0, 1, 8'hC3, 4'h9);
      if (i < 4)
        chk($sformatf("full_tick%0d", i), 1'b0, get(1'b1),
            o(1, 6'(i), 12'hC39, (i < 3), (i >= 3), 7'(i + 1)));
      else
        chk($sformatf("full_tick%0d", i), 1'b0, get(1'b1), o(0,0,12'h000,0,1,4));
    end
    drive(1'b1, 0, 0, 0, 8'h00, 4'h0);
    chk("full_hold", 1'b0, get(1'b1), o(0,0,12'h000,0,1,4));

    // Key change one cycle before the tick, then three cycles before.
    drive(1'b0, 1, 0, 0, 8'h00, 4'h0);
    chk("sync_start", 1'b0, get(1'b0), o(0,0,12'h000,1,0,0));
    drive(1'b0, 0, 0, 0, 8'h00, 4'h0);
    drive(1'b0, 0, 0, 0, 8'h00, 4'h0);
    drive(1'b0, 0, 0, 0, 8'hAA, 4'hA);
    drive(1'b0, 0, 0, 1, 8'hAA, 4'hA);
    chk("sync_late_change", 1'b0, get(1'b0), o(1, 0, SYNC ? 12'h000 : 12'hAAA, 1, 0, 1));
    drive(1'b0, 0, 0, 0, 8'h55, 4'h5);
    drive(1'b0, 0, 0, 0, 8'h55, 4'h5);
    drive(1'b0, 0, 0, 0, 8'h55, 4'h5);
    drive(1'b0, 0, 0, 1, 8'h55, 4'h5);
    chk("sync_early_change", 1'b0, get(1'b0), o(1,1,12'h555,1,0,2));
    drive(1'b0, 0, 1, 0, 8'h00, 4'h0);
    chk("sync_stop", 1'b0, get(1'b0), o(0,0,12'h000,0,1,2));

    // Reset mid-RECORD after five notes: outputs clear before any clock edge.
    drive(1'b0, 1, 0, 0, 8'h00, 4'h0);
    for (int i = 0; i < 5; i++) drive(1'b0, 0, 0, 1, 8'h00, 4'h0);
    chk("five_notes", 1'b0, get(1'b0), o(1,4,12'h000,1,0,5));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 1'b1, get(1'b0), o(0,0,12'h000,0,0,0));
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 0, 0, 1, 8'h77, 4'h7);
    chk("idle_after_reset", 1'b0, get(1'b0), o(0,0,12'h000,0,0,0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
